// File: rtl/cv_pkg.sv
// Shared types and constants for the per-frame render sequencer.
// Imported by the sequencer top.
package cv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_REQ,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int         ENTRY_EN_BIT = 7;
  localparam logic [2:0] SPRITE_LAYER = 3'd7;
  localparam int         NUM_SLOT_MAX = 8;

endpackage

// File: rtl/cv_rend_wdog.sv
// Per-job watchdog: counts while enabled, expires as the count
// reaches 2**TMO_W-1.
module cv_rend_wdog #(
  parameter int TMO_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  // Fires in the cycle whose increment would land on the all-ones value.
  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/cv_rend_seq.sv
// Per-frame render sequencer: walks the render-order slots and
// issues one req/ack/done job per enabled slot.
module cv_rend_seq
  import cv_pkg::*;
#(
  parameter int NUM_SLOT = 8,
  parameter int TMO_W    = 16
) (
  input  logic        ps_c_clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic [2:0]  rend_order_sel,
  input  logic [7:0]  r_rend_order,
  input  logic [15:0] r_sp_count,
  input  logic [1:0]  r_virq,
  output logic        rend_req,
  output logic [2:0]  rend_layer,
  output logic [15:0] rend_sp_count,
  input  logic        rend_ack,
  input  logic        rend_done,
  output logic        busy,
  output logic        frame_done,
  output logic        irq,
  output logic        overrun,
  output logic        rend_timeout
);

  localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOT - 1);

  state_t     state, state_nx;
  logic [2:0] slot;
  logic       wd_exp;
  logic       ld_slot0, inc_slot, ld_job, set_tmo;
  logic       unused_bits;

  assign unused_bits = ^r_rend_order[6:3];

  cv_rend_wdog #(.TMO_W(TMO_W)) u_wdog (
    .clk    (ps_c_clk),
    .reset  (reset),
    .clr    (state != S_RUN),
    .en     (state == S_RUN),
    .expire (wd_exp)
  );

  always_ff @(posedge ps_c_clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_slot0 = 1'b0;
    inc_slot = 1'b0;
    ld_job   = 1'b0;
    set_tmo  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_nx = S_SEL;
          ld_slot0 = 1'b1;
        end
      end
      S_SEL: begin
        if (r_rend_order[ENTRY_EN_BIT]) begin
          state_nx = S_REQ;
          ld_job   = 1'b1;
        end else begin
          state_nx = S_NEXT;
        end
      end
      S_REQ: begin
        if (rend_ack)
          state_nx = S_RUN;
      end
      // Done takes priority over a coincident watchdog expiry.
      S_RUN: begin
        if (rend_done) begin
          state_nx = S_NEXT;
        end else if (wd_exp) begin
          state_nx = S_NEXT;
          set_tmo  = 1'b1;
        end
      end
      S_NEXT: begin
        if (slot == LAST_SLOT) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_SEL;
          inc_slot = 1'b1;
        end
      end
      S_DONE: begin
        if (frame_start) begin
          state_nx = S_SEL;
          ld_slot0 = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ps_c_clk) begin
    if (reset) begin
      slot          <= '0;
      rend_layer    <= '0;
      rend_sp_count <= '0;
      rend_timeout  <= 1'b0;
      irq           <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (ld_slot0)
        slot <= '0;
      else if (inc_slot)
        slot <= slot + 3'd1;
      if (ld_job) begin
        rend_layer    <= r_rend_order[2:0];
        rend_sp_count <= (r_rend_order[2:0] == SPRITE_LAYER)
                         ? r_sp_count : '0;
      end
      if (ld_slot0)
        rend_timeout <= 1'b0;
      else if (set_tmo)
        rend_timeout <= 1'b1;
      // Set beats a coincident clear.
      if (state == S_DONE && r_virq[0])
        irq <= 1'b1;
      else if (r_virq[1] || !r_virq[0])
        irq <= 1'b0;
      overrun <= frame_start &&
                 (state inside {S_SEL, S_REQ, S_RUN, S_NEXT});
    end
  end

  assign rend_order_sel = slot;
  assign rend_req       = (state == S_REQ);
  assign busy           = (state != S_IDLE);
  assign frame_done     = (state == S_DONE);

endmodule

// File: tb/tb_cv_rend_seq.sv
// Scoreboard bench for cv_rend_seq: jobs are queued by the stimulus
// and popped by a monitor at each req/ack handshake.
module tb_cv_rend_seq;

  typedef struct {
    logic [2:0]  layer;
    logic [15:0] sp;
  } job_t;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [2:0]  rend_order_sel;
  logic [7:0]  r_rend_order;
  logic [15:0] r_sp_count;
  logic [1:0]  r_virq;
  logic        rend_req;
  logic [2:0]  rend_layer;
  logic [15:0] rend_sp_count;
  logic        rend_ack;
  logic        rend_done;
  logic        busy;
  logic        frame_done;
  logic        irq;
  logic        overrun;
  logic        rend_timeout;

  logic [7:0] tab [8];
  job_t       exp_q [$];
  int         total = 0;
  int         bad = 0;
  int         fd_cnt = 0;
  int         ack_dly = 1;
  int         done_dly = 3;
  bit         no_done = 0;

  assign r_rend_order = tab[rend_order_sel];

  cv_rend_seq #(.NUM_SLOT(8), .TMO_W(4)) dut (
    .ps_c_clk       (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .rend_order_sel (rend_order_sel),
    .r_rend_order   (r_rend_order),
    .r_sp_count     (r_sp_count),
    .r_virq         (r_virq),
    .rend_req       (rend_req),
    .rend_layer     (rend_layer),
    .rend_sp_count  (rend_sp_count),
    .rend_ack       (rend_ack),
    .rend_done      (rend_done),
    .busy           (busy),
    .frame_done     (frame_done),
    .irq            (irq),
    .overrun        (overrun),
    .rend_timeout   (rend_timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // Renderer model
  initial begin
    rend_ack  = 0;
    rend_done = 0;
    forever begin
      @(posedge clk); #1;
      if (rend_req && !reset) begin
        repeat (ack_dly) begin @(posedge clk); #1; end
        rend_ack = 1;
        @(posedge clk); #1;
        rend_ack = 0;
        if (!no_done) begin
          repeat (done_dly - 1) begin @(posedge clk); #1; end
          rend_done = 1;
          @(posedge clk); #1;
          rend_done = 0;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    job_t e;
    if (frame_done) fd_cnt++;
    if (rend_req && rend_ack && !reset) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL job_unexpected layer=%0d sp=%h", rend_layer,
                 rend_sp_count);
      end else begin
        e = exp_q.pop_front();
        chk("job_layer", 32'(rend_layer), 32'(e.layer));
        chk("job_sp", 32'(rend_sp_count), 32'(e.sp));
      end
    end
  end

  task automatic pulse_fs();
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
  endtask

  task automatic wait_fd(input int lim);
    int n = 0;
    forever begin
      @(negedge clk);
      if (frame_done) break;
      n++;
      if (n > lim) begin
        total++;
        bad++;
        $display("FAIL wait_frame_done expired after %0d", lim);
        break;
      end
    end
  endtask

  task automatic wait_ack(input int lim);
    int n = 0;
    forever begin
      @(negedge clk);
      if (rend_req && rend_ack) break;
      n++;
      if (n > lim) begin
        total++;
        bad++;
        $display("FAIL wait_ack expired after %0d", lim);
        break;
      end
    end
  endtask

  task automatic clr_tab();
    for (int i = 0; i < 8; i++) tab[i] = 8'h00;
  endtask

  initial begin
    int fd0;
    reset       = 1;
    frame_start = 0;
    r_sp_count  = 16'h0;
    r_virq      = 2'b00;
    clr_tab();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(rend_req), 0);
    chk("rst_sel", 32'(rend_order_sel), 0);
    chk("rst_sp", 32'(rend_sp_count), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_irq", 32'(irq), 0);

    // 1: all slots disabled
    pulse_fs();
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk($sformatf("t1_busy_c%0d", k), 32'(busy), 1);
      chk($sformatf("t1_fd_c%0d", k), 32'(frame_done), 32'(k == 17));
    end
    @(negedge clk);
    chk("t1_busy_end", 32'(busy), 0);

    // 2: two jobs, sprite layer forwarding
    tab[0]     = 8'h87;
    tab[1]     = 8'h82;
    r_sp_count = 16'h0123;
    ack_dly    = 2;
    done_dly   = 5;
    exp_q.push_back('{3'd7, 16'h0123});
    exp_q.push_back('{3'd2, 16'h0000});
    fd0 = fd_cnt;
    pulse_fs();
    wait_fd(200);
    repeat (5) @(negedge clk);
    chk("t2_fd_once", 32'(fd_cnt - fd0), 1);
    chk("t2_q_empty", 32'(exp_q.size()), 0);

    // 3: irq set/clear
    clr_tab();
    r_virq = 2'b01;
    pulse_fs();
    wait_fd(40);
    @(negedge clk);
    chk("t3_irq_set", 32'(irq), 1);
    @(posedge clk); #1 r_virq = 2'b11;
    @(posedge clk); #1 r_virq = 2'b01;
    @(negedge clk);
    chk("t3_irq_clr", 32'(irq), 0);
    pulse_fs();
    repeat (16) @(posedge clk);
    #1 r_virq = 2'b11;
    @(negedge clk);
    chk("t3_fd_coinc", 32'(frame_done), 1);
    @(posedge clk); #1 r_virq = 2'b00;
    @(negedge clk);
    chk("t3_set_wins", 32'(irq), 1);
    pulse_fs();
    wait_fd(40);
    @(negedge clk);
    chk("t3_irq_disabled", 32'(irq), 0);

    // 4: overrun in RUN, back-to-back start in DONE
    tab[0]   = 8'h81;
    ack_dly  = 0;
    done_dly = 8;
    exp_q.push_back('{3'd1, 16'h0000});
    pulse_fs();
    wait_ack(100);
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
    @(negedge clk);
    chk("t4_overrun", 32'(overrun), 1);
    wait_fd(100);
    chk("t4_busy_done", 32'(busy), 1);
    clr_tab();
    pulse_fs();
    repeat (16) @(posedge clk);
    #1 frame_start = 1;
    @(negedge clk);
    chk("t4_fd_b2b", 32'(frame_done), 1);
    @(posedge clk); #1 frame_start = 0;
    @(negedge clk);
    chk("t4_no_overrun", 32'(overrun), 0);
    chk("t4_b2b_busy", 32'(busy), 1);
    chk("t4_b2b_fd", 32'(frame_done), 0);
    chk("t4_b2b_sel", 32'(rend_order_sel), 0);
    wait_fd(40);

    // 5: watchdog with TMO_W=4
    tab[0]  = 8'h83;
    no_done = 1;
    exp_q.push_back('{3'd3, 16'h0000});
    pulse_fs();
    wait_ack(100);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("t5_tmo_early", 32'(rend_timeout), 0);
      if (k == 16) chk("t5_tmo_set", 32'(rend_timeout), 1);
    end
    wait_fd(100);
    chk("t5_tmo_sticky", 32'(rend_timeout), 1);
    exp_q.push_back('{3'd3, 16'h0000});
    pulse_fs();
    @(negedge clk);
    chk("t5_tmo_clr", 32'(rend_timeout), 0);
    wait_fd(100);

    // 6: reset mid-job
    tab[0]     = 8'h87;
    r_sp_count = 16'h0055;
    exp_q.push_back('{3'd7, 16'h0055});
    pulse_fs();
    wait_ack(100);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_req", 32'(rend_req), 0);
    chk("t6_layer", 32'(rend_layer), 0);
    chk("t6_sp", 32'(rend_sp_count), 0);
    chk("t6_sel", 32'(rend_order_sel), 0);
    chk("t6_fd", 32'(frame_done), 0);
    clr_tab();
    tab[2]  = 8'h84;
    no_done = 0;
    done_dly = 3;
    exp_q.push_back('{3'd4, 16'h0000});
    pulse_fs();
    @(negedge clk);
    chk("t6_restart_sel", 32'(rend_order_sel), 0);
    chk("t6_restart_busy", 32'(busy), 1);
    wait_fd(100);
    repeat (3) @(negedge clk);
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
